// File: rtl/vscale_hasti_sram.sv
// AHB-Lite (HASTI) slave SRAM with byte/half/word lanes, configurable
// data-phase wait states and the two-cycle ERROR response.
module vscale_hasti_sram #(
  parameter int nwords      = 1024,
  parameter int wait_cycles = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int          AW       = (nwords > 1) ? $clog2(nwords) : 1;
  localparam logic [31:0] NWORDS32 = 32'(nwords);
  localparam logic [3:0]  WAIT4    = 4'(wait_cycles);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;

  logic [31:0] mem [nwords];

  logic          accept_s;
  logic          error_s;
  logic          we_s;
  logic [3:0]    mask_s;
  logic [AW-1:0] idx_s;
  logic          unused_s;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = 4'b0011 << a;
      3'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  assign idx_s    = addr_q[AW+1:2];
  assign mask_s   = lane_mask(size_q, addr_q[1:0]);
  assign unused_s = ^{hburst, hmastlock, hprot, addr_q[31:AW+2]};

  // Response outputs are decoded straight from the registered state.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        hready = 1'b1;
        hresp  = 1'b0;
      end
      ST_DATA: begin
        hready = (cnt_q == 4'd0);
        hresp  = 1'b0;
        hrdata = mem[idx_s];
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default: begin
        hready = 1'b1;
        hresp  = 1'b0;
      end
    endcase
  end

  assign accept_s = hready & htrans[1];
  assign we_s     = (state_q == ST_DATA) && (cnt_q == 4'd0) && write_q;

  // Transfer legality: range, illegal size, and natural alignment.
  always_comb begin
    error_s = 1'b0;
    if ({2'b00, haddr[31:2]} >= NWORDS32) begin
      error_s = 1'b1;
    end else if (hsize > 3'd2) begin
      error_s = 1'b1;
    end else if ((hsize == 3'd1) && haddr[0]) begin
      error_s = 1'b1;
    end else if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
      error_s = 1'b1;
    end else begin
      error_s = 1'b0;
    end
  end

  // Next-state logic; any cycle with hready high may start a new beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_DATA: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (hready) begin
      if (accept_s) begin
        addr_d  = haddr;
        write_d = hwrite;
        size_d  = hsize;
        state_d = error_s ? ST_ERR1 : ST_DATA;
        cnt_d   = error_s ? 4'd0 : WAIT4;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // State and registered address-phase control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0000_0000;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Storage is deliberately not reset; writes commit on the final data edge.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_s[i]) begin
          mem[idx_s][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_vscale_hasti_sram.sv
// Directed bench: three SRAM instances (0, 1, 2 wait states) sharing one
// master; htrans is steered to the instance selected by sel.
module tb_vscale_hasti_sram;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [1:0]  sel;

  logic [31:0] hrdata_w [3];
  logic        hready_w [3];
  logic        hresp_w  [3];
  logic [31:0] hrdata_s;
  logic        hready_s;
  logic        hresp_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vscale_hasti_sram #(.nwords(16), .wait_cycles(g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (3'd0),
      .hmastlock (1'b0),
      .hprot     (4'd0),
      .htrans    ((sel == 2'(g)) ? htrans : 2'b00),
      .hwdata    (hwdata),
      .hrdata    (hrdata_w[g]),
      .hready    (hready_w[g]),
      .hresp     (hresp_w[g])
    );
  end

  assign hrdata_s = hrdata_w[sel];
  assign hready_s = hready_w[sel];
  assign hresp_s  = hresp_w[sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = 2'b10;
  endtask

  task automatic idle();
    htrans = 2'b00;
  endtask

  task automatic rsp(input string tag, input logic rdy, input logic err);
    check({tag, "_hready"}, {31'd0, hready_s}, {31'd0, rdy});
    check({tag, "_hresp"},  {31'd0, hresp_s},  {31'd0, err});
  endtask

  initial begin
    reset = 1'b1; sel = 2'd0; haddr = 32'd0; hwrite = 1'b0;
    hsize = 3'd2; htrans = 2'b00; hwdata = 32'd0;
    #12;
    rsp("reset", 1'b1, 1'b0);
    check("reset_hrdata", hrdata_s, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Zero-wait word write then back-to-back read.
    addr_ph(32'h10, 1'b1, 3'd2);
    rsp("w0_idle", 1'b1, 1'b0);
    step();
    hwdata = 32'hDEAD_BEEF;
    addr_ph(32'h10, 1'b0, 3'd2);
    rsp("w0_wdata", 1'b1, 1'b0);
    step();
    idle();
    rsp("w0_rdata", 1'b1, 1'b0);
    check("w0_rd_word", hrdata_s, 32'hDEAD_BEEF);
    step();
    check("w0_idle_hrdata", hrdata_s, 32'h0);

    // Byte and half lanes: extra bytes in hwdata must be masked off.
    addr_ph(32'h0, 1'b1, 3'd2);
    step();
    hwdata = 32'h0000_0000;
    addr_ph(32'h1, 1'b1, 3'd0);
    step();
    hwdata = 32'hAAAA_AAAA;
    addr_ph(32'h2, 1'b1, 3'd1);
    step();
    hwdata = 32'h1234_5678;
    addr_ph(32'h0, 1'b0, 3'd2);
    step();
    idle();
    check("lanes_rd", hrdata_s, 32'h1234_AA00);
    step();

    // Misaligned half read: two-cycle ERROR.
    addr_ph(32'h3, 1'b0, 3'd1);
    step();
    idle();
    rsp("err_half_c1", 1'b0, 1'b1);
    step();
    rsp("err_half_c2", 1'b1, 1'b1);
    step();
    rsp("err_half_done", 1'b1, 1'b0);

    // Out-of-range word write (aliases word 0 if wrongly committed).
    addr_ph(32'h40, 1'b1, 3'd2);
    step();
    hwdata = 32'hFFFF_FFFF;
    idle();
    rsp("err_range_c1", 1'b0, 1'b1);
    step();
    rsp("err_range_c2", 1'b1, 1'b1);
    addr_ph(32'h0, 1'b0, 3'd2);
    step();
    idle();
    check("err_range_mem", hrdata_s, 32'h1234_AA00);
    step();

    // hsize = 3 is illegal; a read issued during ERR2 must be accepted.
    addr_ph(32'h0, 1'b1, 3'd3);
    step();
    idle();
    rsp("err_size_c1", 1'b0, 1'b1);
    step();
    rsp("err_size_c2", 1'b1, 1'b1);
    addr_ph(32'h0, 1'b0, 3'd2);
    step();
    idle();
    rsp("err_size_next", 1'b1, 1'b0);
    check("err_size_mem", hrdata_s, 32'h1234_AA00);
    step();

    // Pipelined write chain then read of the same word, zero wait.
    addr_ph(32'h14, 1'b1, 3'd2);
    step();
    hwdata = 32'hFFFF_FFFF;
    step();
    hwdata = 32'h0000_0055;
    addr_ph(32'h14, 1'b0, 3'd2);
    step();
    idle();
    rsp("pipe0_rd", 1'b1, 1'b0);
    check("pipe0_data", hrdata_s, 32'h0000_0055);
    step();

    // Same with one wait state; address held while hready is low.
    sel = 2'd1;
    addr_ph(32'h14, 1'b1, 3'd2);
    step();
    hwdata = 32'hFFFF_FFFF;
    idle();
    rsp("pipe1_w1_wait", 1'b0, 1'b0);
    step();
    rsp("pipe1_w1_last", 1'b1, 1'b0);
    addr_ph(32'h14, 1'b1, 3'd2);
    step();
    hwdata = 32'h0000_0055;
    addr_ph(32'h14, 1'b0, 3'd2);
    rsp("pipe1_w2_wait", 1'b0, 1'b0);
    step();
    rsp("pipe1_w2_last", 1'b1, 1'b0);
    step();
    idle();
    rsp("pipe1_rd_wait", 1'b0, 1'b0);
    step();
    rsp("pipe1_rd_last", 1'b1, 1'b0);
    check("pipe1_data", hrdata_s, 32'h0000_0055);
    step();

    // Two wait states: seed word 2, then read it with noise on the address bus.
    sel = 2'd2;
    addr_ph(32'h8, 1'b1, 3'd2);
    step();
    hwdata = 32'hCAFE_F00D;
    idle();
    step();
    step();
    step();
    addr_ph(32'h8, 1'b0, 3'd2);
    step();
    addr_ph(32'h3C, 1'b1, 3'd0);
    hwdata = 32'h0BAD_0BAD;
    rsp("ws_c1", 1'b0, 1'b0);
    step();
    idle();
    rsp("ws_c2", 1'b0, 1'b0);
    step();
    rsp("ws_c3", 1'b1, 1'b0);
    check("ws_data", hrdata_s, 32'hCAFE_F00D);
    step();
    rsp("ws_idle", 1'b1, 1'b0);
    check("ws_idle_hrdata", hrdata_s, 32'h0);

    // Reset during the second wait cycle of a write to 0x20.
    addr_ph(32'h20, 1'b1, 3'd2);
    step();
    hwdata = 32'h1122_3344;
    idle();
    step();
    step();
    step();
    addr_ph(32'h20, 1'b1, 3'd2);
    step();
    hwdata = 32'h9999_9999;
    idle();
    step();
    rsp("rst_pre", 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    rsp("rst_async", 1'b1, 1'b0);
    step();
    step();
    reset = 1'b0;
    addr_ph(32'h20, 1'b0, 3'd2);
    step();
    idle();
    step();
    step();
    rsp("rst_rd_last", 1'b1, 1'b0);
    check("rst_mem", hrdata_s, 32'h1122_3344);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
